// File: rtl/pulse_stretch.sv
// pulse_stretch: per-lane event-to-pulse generator. Each one-cycle event on
// A[i] becomes a HIGH_CYC-wide pulse on Y[i] followed by at least LOW_CYC low
// cycles; events arriving while a lane is busy are queued (up to MAX_PEND)
// and replayed back-to-back, extra events are dropped and flagged in ovf.

module pulse_stretch_lane #(
  parameter int HIGH_CYC = 4,
  parameter int LOW_CYC  = 2,
  parameter int MAX_PEND = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic ovf_clr,
  output logic y,
  output logic busy,
  output logic ovf
);
  localparam int CMAX = (HIGH_CYC > LOW_CYC) ? HIGH_CYC : LOW_CYC;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int PW   = $clog2(MAX_PEND + 1);

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   pend_q, pend_d;
  logic            y_q, y_d;
  logic            busy_q, busy_d;
  logic            ovf_q, ovf_d;
  logic            queue_ev;
  logic            drop;

  // Event arrives while the lane cannot start a pulse next cycle: it must be
  // queued. The final LOW cycle is excluded because it frees a slot itself.
  assign queue_ev = a && ((state_q == S_HIGH) ||
                          ((state_q == S_LOW) && (cnt_q != '0)));

  // Next-state, counter, pending queue and registered output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    drop    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (a) begin
          state_d = S_HIGH;
          cnt_d   = CW'(HIGH_CYC - 1);
        end
      end
      S_HIGH: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = S_LOW;
          cnt_d   = CW'(LOW_CYC - 1);
        end
      end
      S_LOW: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (pend_q != '0) begin
          // Replay a queued event; a new event refills the slot just freed.
          state_d = S_HIGH;
          cnt_d   = CW'(HIGH_CYC - 1);
          pend_d  = pend_q - PW'(1) + PW'(a);
        end else if (a) begin
          state_d = S_HIGH;
          cnt_d   = CW'(HIGH_CYC - 1);
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        pend_d  = '0;
      end
    endcase

    if (queue_ev) begin
      if (pend_q < PW'(MAX_PEND)) pend_d = pend_q + PW'(1);
      else                        drop   = 1'b1;
    end

    y_d    = (state_d == S_HIGH);
    busy_d = (state_d != S_IDLE);
    // A drop in the same cycle as a clear keeps the flag set.
    ovf_d  = (ovf_q & ~ovf_clr) | drop;
  end

  // Lane state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      y_q     <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  assign y    = y_q;
  assign busy = busy_q;
  assign ovf  = ovf_q;
endmodule

module pulse_stretch #(
  parameter int WIDTH    = 1,
  parameter int HIGH_CYC = 4,
  parameter int LOW_CYC  = 2,
  parameter int MAX_PEND = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] busy,
  output logic [WIDTH-1:0] ovf
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    pulse_stretch_lane #(
      .HIGH_CYC (HIGH_CYC),
      .LOW_CYC  (LOW_CYC),
      .MAX_PEND (MAX_PEND)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .a       (A[i]),
      .ovf_clr (ovf_clr),
      .y       (Y[i]),
      .busy    (busy[i]),
      .ovf     (ovf[i])
    );
  end
endmodule

// File: tb/tb_pulse_stretch.sv
// Bench for pulse_stretch (WIDTH=2, HIGH_CYC=3, LOW_CYC=2, MAX_PEND=2).
// Reference model keeps, per lane, the list of scheduled pulse start cycles
// and derives Y/busy/ovf from those intervals.

module tb_pulse_stretch;
  localparam int W = 2;
  localparam int H = 3;
  localparam int L = 2;
  localparam int P = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] A = '0;
  logic         ovf_clr = 1'b0;
  logic [W-1:0] Y, busy, ovf;

  pulse_stretch #(.WIDTH(W), .HIGH_CYC(H), .LOW_CYC(L), .MAX_PEND(P)) dut (
    .clk(clk), .rst(rst), .A(A), .ovf_clr(ovf_clr),
    .Y(Y), .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int base = 0;

  int           starts[W][$];
  logic [W-1:0] movf = '0;
  logic [W-1:0] ey, eb, eo;

  // True if cycle n lies within len cycles of any scheduled start on lane l.
  function automatic logic m_act(int l, int n, int len);
    for (int k = 0; k < starts[l].size(); k++)
      if (n >= starts[l][k] && n < starts[l][k] + len) return 1'b1;
    return 1'b0;
  endfunction

  // Apply the inputs of cycle n to the schedule model.
  task automatic model_update(input logic [W-1:0] a, input logic clr, input logic r, input int n);
    logic [W-1:0] drop;
    int last, waiting;
    drop = '0;
    if (r) begin
      for (int l = 0; l < W; l++) starts[l].delete();
      movf = '0;
      return;
    end
    for (int l = 0; l < W; l++) begin
      if (a[l]) begin
        if (starts[l].size() == 0) starts[l].push_back(n + 1);
        else begin
          last = starts[l][starts[l].size()-1];
          if (n >= last + H + L - 1) starts[l].push_back(n + 1);
          else begin
            waiting = 0;
            for (int k = 0; k < starts[l].size(); k++)
              if (starts[l][k] > n + 1) waiting++;
            if (waiting < P) starts[l].push_back(last + H + L);
            else drop[l] = 1'b1;
          end
        end
      end
    end
    movf = (movf & ~{W{clr}}) | drop;
  endtask

  // Drive one cycle of inputs, advance model and clock, compute expectations.
  task automatic step(input logic [W-1:0] a, input logic clr, input logic r);
    A = a; ovf_clr = clr; rst = r;
    model_update(a, clr, r, cyc);
    @(posedge clk); #1;
    cyc++;
    for (int l = 0; l < W; l++) begin
      ey[l] = m_act(l, cyc, H);
      eb[l] = m_act(l, cyc, H + L);
    end
    eo = movf;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(2'($urandom_range(0, 3)), 1'b0, 1'b1);
      n_chk++;
      if ({Y, busy, ovf} !== 6'b0)
        $display("FAIL reset cyc=%0d got Y=%b busy=%b ovf=%b exp all 0", cyc, Y, busy, ovf);
      else n_pass++;
    end
  endtask

  task automatic test_single();
    int lt;
    step(2'b00, 1'b0, 1'b1); base = cyc;
    for (int t = 0; t < 20; t++) begin
      step((t == 10) ? 2'b01 : 2'b00, 1'b0, 1'b0); lt = cyc - base;
      n_chk++;
      if ({Y, busy, ovf} !== {ey, eb, eo})
        $display("FAIL single_model t=%0d got %b/%b/%b exp %b/%b/%b", lt, Y, busy, ovf, ey, eb, eo);
      else n_pass++;
      n_chk++;
      if (Y[0] !== (lt >= 11 && lt <= 13) || busy[0] !== (lt >= 11 && lt <= 15) || Y[1] !== 1'b0 || busy[1] !== 1'b0)
        $display("FAIL single_timing t=%0d got Y=%b busy=%b", lt, Y, busy);
      else n_pass++;
    end
  endtask

  task automatic test_queue();
    int lt;
    logic exp_y;
    step(2'b00, 1'b0, 1'b1); base = cyc;
    for (int t = 0; t < 30; t++) begin
      step((t >= 10 && t <= 12) ? 2'b01 : 2'b00, 1'b0, 1'b0); lt = cyc - base;
      exp_y = (lt >= 11 && lt < 24 && ((lt - 11) % 5) < 3);
      n_chk++;
      if ({Y, busy, ovf} !== {ey, eb, eo})
        $display("FAIL queue_model t=%0d got %b/%b/%b exp %b/%b/%b", lt, Y, busy, ovf, ey, eb, eo);
      else n_pass++;
      n_chk++;
      if (Y[0] !== exp_y || busy[0] !== (lt >= 11 && lt <= 25) || ovf[0] !== 1'b0)
        $display("FAIL queue_timing t=%0d got Y=%b busy=%b ovf=%b exp Y0=%b", lt, Y, busy, ovf, exp_y);
      else n_pass++;
    end
  endtask

  task automatic test_overflow();
    int lt;
    logic exp_o, exp_y;
    logic [W-1:0] a;
    step(2'b00, 1'b0, 1'b1); base = cyc;
    for (int t = 0; t < 50; t++) begin
      a = ((t >= 10 && t <= 13) || (t >= 40 && t <= 43)) ? 2'b01 : 2'b00;
      step(a, (t == 30 || t == 43), 1'b0); lt = cyc - base;
      exp_o = (lt >= 14 && lt <= 30) || (lt >= 44);
      exp_y = (lt >= 11 && lt < 24 && ((lt - 11) % 5) < 3);
      n_chk++;
      if ({Y, busy, ovf} !== {ey, eb, eo})
        $display("FAIL ovf_model t=%0d got %b/%b/%b exp %b/%b/%b", lt, Y, busy, ovf, ey, eb, eo);
      else n_pass++;
      n_chk++;
      if (ovf[0] !== exp_o || ovf[1] !== 1'b0 || (lt < 40 && Y[0] !== exp_y))
        $display("FAIL ovf_timing t=%0d got Y=%b ovf=%b exp ovf0=%b Y0=%b", lt, Y, ovf, exp_o, exp_y);
      else n_pass++;
    end
  endtask

  task automatic test_final_low();
    int lt;
    logic exp_y;
    logic [W-1:0] a;
    step(2'b00, 1'b0, 1'b1); base = cyc;
    for (int t = 0; t < 65; t++) begin
      a = (t == 10 || t == 15 || t == 40 || t == 41 || t == 42 || t == 45) ? 2'b01 : 2'b00;
      step(a, 1'b0, 1'b0); lt = cyc - base;
      exp_y = (lt >= 11 && lt < 19 && ((lt - 11) % 5) < 3) ||
              (lt >= 41 && lt < 59 && ((lt - 41) % 5) < 3);
      n_chk++;
      if ({Y, busy, ovf} !== {ey, eb, eo})
        $display("FAIL final_low_model t=%0d got %b/%b/%b exp %b/%b/%b", lt, Y, busy, ovf, ey, eb, eo);
      else n_pass++;
      n_chk++;
      if (Y[0] !== exp_y || ovf !== 2'b00)
        $display("FAIL final_low_timing t=%0d got Y=%b ovf=%b exp Y0=%b ovf=00", lt, Y, ovf, exp_y);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int lt;
    logic [W-1:0] a;
    step(2'b00, 1'b0, 1'b1); base = cyc;
    for (int t = 0; t < 30; t++) begin
      a = (t == 10 || t == 11 || t == 20) ? 2'b01 : 2'b00;
      step(a, 1'b0, (t == 12)); lt = cyc - base;
      n_chk++;
      if ({Y, busy, ovf} !== {ey, eb, eo})
        $display("FAIL reset_mid_model t=%0d got %b/%b/%b exp %b/%b/%b", lt, Y, busy, ovf, ey, eb, eo);
      else n_pass++;
      n_chk++;
      if ((lt >= 13 && lt <= 20 && {Y, busy, ovf} !== 6'b0) ||
          (lt >= 21 && lt <= 23 && Y[0] !== 1'b1) || (lt >= 24 && Y[0] !== 1'b0))
        $display("FAIL reset_mid_timing t=%0d got Y=%b busy=%b ovf=%b", lt, Y, busy, ovf);
      else n_pass++;
    end
  endtask

  task automatic test_indep();
    int lt;
    logic [W-1:0] a;
    step(2'b00, 1'b0, 1'b1); base = cyc;
    for (int t = 0; t < 25; t++) begin
      a = (t == 10) ? 2'b11 : (t == 11) ? 2'b01 : 2'b00;
      step(a, 1'b0, 1'b0); lt = cyc - base;
      n_chk++;
      if ({Y, busy, ovf} !== {ey, eb, eo})
        $display("FAIL indep_model t=%0d got %b/%b/%b exp %b/%b/%b", lt, Y, busy, ovf, ey, eb, eo);
      else n_pass++;
      n_chk++;
      if (Y[1] !== (lt >= 11 && lt <= 13) || Y[0] !== ((lt >= 11 && lt <= 13) || (lt >= 16 && lt <= 18)))
        $display("FAIL indep_timing t=%0d got Y=%b", lt, Y);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a;
    step(2'b00, 1'b0, 1'b1);
    for (int t = 0; t < 1500; t++) begin
      for (int l = 0; l < W; l++) a[l] = ($urandom_range(0, 3) == 0);
      step(a, ($urandom_range(0, 15) == 0), ($urandom_range(0, 199) == 0));
      n_chk++;
      if ({Y, busy, ovf} !== {ey, eb, eo})
        $display("FAIL random_model cyc=%0d got %b/%b/%b exp %b/%b/%b", cyc, Y, busy, ovf, ey, eb, eo);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_queue();
    test_overflow();
    test_final_low();
    test_reset_mid();
    test_indep();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
